// File: rtl/spi_master_param_if.sv
// Bus bundle between the SPI master and its user: start/receive handshake plus the serial pins.
// "master" is the view taken by the SPI master itself, "slave" the view of whoever drives it.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int SEL_W  = 2
);
  logic [DATA_W-1:0] start_data;
  logic [SEL_W-1:0]  start_sel;
  logic [1:0]        start_mode;
  logic              start_hold;
  logic              EN_start;
  logic              RDY_start;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              EN_rx;
  logic              EN_release;
  logic              busy;
  logic              miso;
  logic              sck;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start_data, start_sel, start_mode, start_hold, EN_start, EN_rx, EN_release, miso,
    output RDY_start, rx_data, rx_valid, busy, sck, mosi, ss_n
  );

  modport slave (
    output start_data, start_sel, start_mode, start_hold, EN_start, EN_rx, EN_release, miso,
    input  RDY_start, rx_data, rx_valid, busy, sck, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCK divider, per-word CPOL/CPHA,
// several active-low slave selects and chip-select hold across multi-word bursts.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 4,
  parameter int SEL_W   = 2
) (
  input logic                CLK,
  input logic                RST_N,
  spi_master_param_if.master bus
);
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_DESEL, S_SETUP, S_SHIFT, S_TAIL, S_HOLD} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_rx_shift;
  logic [DATA_W-1:0]   r_rx_data;
  logic [SEL_W-1:0]    r_sel;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_hold;
  logic                r_rx_valid;
  logic                r_sck;
  logic                r_mosi;
  logic [NUM_SS-1:0]   r_ss_n;

  logic [NUM_SS-1:0]   w_ss_new;
  logic [NUM_SS-1:0]   w_ss_cur;
  logic                w_rdy;
  logic                w_accept;
  logic                w_div_done;
  logic                w_leading;
  logic                w_sample;
  logic                w_last_edge;

  // A select index with no matching output simply leaves every line high.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_ss
      assign w_ss_new[gi] = (bus.start_sel != SEL_W'(gi));
      assign w_ss_cur[gi] = (r_sel != SEL_W'(gi));
    end
  endgenerate

  assign w_rdy       = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !r_rx_valid;
  assign w_accept    = bus.EN_start && w_rdy;
  assign w_div_done  = (r_div_cnt == CNT_LAST);
  assign w_leading   = ~r_edge_cnt[0];
  assign w_sample    = w_leading ^ r_cpha;
  assign w_last_edge = (r_edge_cnt == EDGE_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sel      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_hold     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
    end else begin
      if (bus.EN_rx && r_rx_valid) r_rx_valid <= 1'b0;

      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            r_tx_shift <= bus.start_data;
            r_sel      <= bus.start_sel;
            r_cpol     <= bus.start_mode[1];
            r_cpha     <= bus.start_mode[0];
            r_hold     <= bus.start_hold;
            r_sck      <= bus.start_mode[1];
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            if ((r_state == S_HOLD) && (bus.start_sel != r_sel)) begin
              r_ss_n  <= '1;
              r_state <= S_DESEL;
            end else begin
              r_ss_n <= w_ss_new;
              if (!bus.start_mode[0]) r_mosi <= bus.start_data[DATA_W-1];
              r_state <= S_SETUP;
            end
          end else if ((r_state == S_HOLD) && bus.EN_release) begin
            r_ss_n  <= '1;
            r_state <= S_IDLE;
          end
        end

        S_DESEL: begin
          if (w_div_done) begin
            r_div_cnt <= '0;
            r_ss_n    <= w_ss_cur;
            if (!r_cpha) r_mosi <= r_tx_shift[DATA_W-1];
            r_state   <= S_SETUP;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_SETUP: begin
          if (w_div_done) begin
            r_div_cnt <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (w_div_done) begin
            r_div_cnt  <= '0;
            r_sck      <= ~r_sck;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            // CPHA=0 already presented the MSB in SETUP, so it drives bit N-2 next.
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[DATA_W-2:0], bus.miso};
            end else if (r_cpha) begin
              r_mosi     <= r_tx_shift[DATA_W-1];
              r_tx_shift <= r_tx_shift << 1;
            end else if (!w_last_edge) begin
              r_mosi     <= r_tx_shift[DATA_W-2];
              r_tx_shift <= r_tx_shift << 1;
            end
            if (w_last_edge) r_state <= S_TAIL;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_TAIL: begin
          if (w_div_done) begin
            r_div_cnt  <= '0;
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            if (r_hold) begin
              r_state <= S_HOLD;
            end else begin
              r_ss_n  <= '1;
              r_state <= S_IDLE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.RDY_start = w_rdy;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sck       = r_sck;
  assign bus.mosi      = r_mosi;
  assign bus.ss_n      = r_ss_n;
endmodule
